ans_freq_counter: RTL and testbench

Upstream model-building stage for the ANS coder. Consumes a block of 4-bit symbols over a valid/ready stream and builds a per-symbol histogram. At end of block it normalizes the histogram to CNT_WIDTH-bit counts. It then streams the 16 counts, symbol 0 first, in exactly the nibble order the ANS loader expects in load mode (cmd = 2'b11).

---
 rtl/ans_freq_counter_pkg.sv | 20 ++
 rtl/ans_hist_norm.sv | 38 +++
 rtl/ans_freq_counter.sv | 136 +++++++++++++
 tb/tb_ans_freq_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ans_freq_counter_pkg.sv
// Shared constants and state encoding for the ANS model-building and coding stages.
package ans_freq_counter_pkg;

  localparam int SYM_WIDTH  = 4;
  localparam int SYM_COUNT  = 2**SYM_WIDTH;
  localparam int CNT_WIDTH  = 4;
  localparam int HIST_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_SCALE = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  // Width needed to hold a shift amount in 0..hist_w-cnt_w.
  function automatic int k_width(input int hist_w, input int cnt_w);
    return $clog2(hist_w - cnt_w + 2);
  endfunction

endpackage

// File: rtl/ans_hist_norm.sv
// Combinational histogram normalizer: picks the shift k from the block maximum
// and maps a raw count h to its CNT_WIDTH-bit normalized value.
module ans_hist_norm #(
  parameter int HIST_WIDTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int K_WIDTH    = 3
) (
  input  logic [HIST_WIDTH-1:0] max_val,
  input  logic [HIST_WIDTH-1:0] h,
  input  logic [K_WIDTH-1:0]    k,
  output logic [K_WIDTH-1:0]    k_calc,
  output logic [CNT_WIDTH-1:0]  norm
);

  localparam int CNT_MAX = 2**CNT_WIDTH - 1;

  logic [HIST_WIDTH-1:0] shifted;

  // Descending scan so the last hit is the smallest qualifying shift.
  always_comb begin
    k_calc = K_WIDTH'(HIST_WIDTH - CNT_WIDTH);
    for (int i = HIST_WIDTH - CNT_WIDTH; i >= 0; i--) begin
      if ((max_val >> i) <= HIST_WIDTH'(CNT_MAX)) k_calc = K_WIDTH'(i);
    end
  end

  // A seen symbol never normalizes to 0, or the coder could not encode it.
  always_comb begin
    shifted = h >> k;
    if (h == '0)
      norm = '0;
    else if (shifted == '0)
      norm = CNT_WIDTH'(1);
    else
      norm = CNT_WIDTH'(shifted);
  end

endmodule

// File: rtl/ans_freq_counter.sv
// Builds a per-symbol histogram over a block, normalizes it, and streams the
// counts (symbol 0 first) in the order the ANS loader expects.
//
// state    | meaning
// ST_COUNT | accepting symbols, updating histogram and running max
// ST_SCALE | one cycle: latch shift k, preload symbol-0 count
// ST_EMIT  | presenting normalized counts on out_cnt/out_vld
module ans_freq_counter
  import ans_freq_counter_pkg::*;
#(
  parameter int SYM_WIDTH  = ans_freq_counter_pkg::SYM_WIDTH,
  parameter int CNT_WIDTH  = ans_freq_counter_pkg::CNT_WIDTH,
  parameter int HIST_WIDTH = ans_freq_counter_pkg::HIST_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SYM_WIDTH-1:0] in_sym,
  input  logic                 in_vld,
  input  logic                 in_last,
  output logic                 in_rdy,
  output logic [CNT_WIDTH-1:0] out_cnt,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 busy
);

  localparam int N_SYM   = 2**SYM_WIDTH;
  localparam int K_WIDTH = k_width(HIST_WIDTH, CNT_WIDTH);
  localparam logic [HIST_WIDTH-1:0] HIST_MAX = '1;
  localparam logic [SYM_WIDTH-1:0]  LAST_IDX = '1;

  state_t                state, state_nxt;
  logic [HIST_WIDTH-1:0] hist [N_SYM];
  logic [HIST_WIDTH-1:0] max_q, rd_val, inc_val;
  logic [K_WIDTH-1:0]    k_q, k_calc, k_sel;
  logic [SYM_WIDTH-1:0]  idx, rd_addr;
  logic [CNT_WIDTH-1:0]  norm_val, out_cnt_q;
  logic                  live, accept, hs, done;

  assign accept = in_vld & in_rdy;
  assign hs     = out_vld & out_rdy;
  assign done   = hs && (idx == LAST_IDX);

  // Single read port: incoming symbol while counting, next emit index otherwise.
  always_comb begin
    case (state)
      ST_COUNT: rd_addr = in_sym;
      ST_SCALE: rd_addr = '0;
      default:  rd_addr = idx + SYM_WIDTH'(1);
    endcase
  end

  assign rd_val  = hist[rd_addr];
  assign inc_val = (rd_val == HIST_MAX) ? rd_val : rd_val + HIST_WIDTH'(1);
  assign k_sel   = (state == ST_SCALE) ? k_calc : k_q;

  ans_hist_norm #(
    .HIST_WIDTH (HIST_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_norm (
    .max_val (max_q),
    .h       (rd_val),
    .k       (k_sel),
    .k_calc  (k_calc),
    .norm    (norm_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_COUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COUNT: if (accept && in_last) state_nxt = ST_SCALE;
      ST_SCALE: state_nxt = ST_EMIT;
      ST_EMIT:  if (done) state_nxt = ST_COUNT;
      default:  state_nxt = ST_COUNT;
    endcase
  end

  always_comb begin
    in_rdy  = live && (state == ST_COUNT);
    out_vld = (state == ST_EMIT);
    busy    = (state != ST_COUNT);
  end

  // Holds in_rdy low until the first clock after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SYM; i++) hist[i] <= '0;
      max_q     <= '0;
      k_q       <= '0;
      idx       <= '0;
      out_cnt_q <= '0;
    end else begin
      case (state)
        ST_COUNT: begin
          if (accept) begin
            hist[in_sym] <= inc_val;
            if (inc_val > max_q) max_q <= inc_val;
          end
        end
        ST_SCALE: begin
          k_q       <= k_calc;
          idx       <= '0;
          out_cnt_q <= norm_val;
        end
        ST_EMIT: begin
          if (hs) begin
            if (idx == LAST_IDX) begin
              for (int i = 0; i < N_SYM; i++) hist[i] <= '0;
              max_q     <= '0;
              idx       <= '0;
              out_cnt_q <= '0;
            end else begin
              idx       <= idx + SYM_WIDTH'(1);
              out_cnt_q <= norm_val;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_cnt = out_cnt_q;

endmodule

// File: tb/tb_ans_freq_counter.sv
// Directed self-checking bench for ans_freq_counter: stimulus and sampling on
// the falling edge, expected streams hand-computed per scenario.
module tb_ans_freq_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_sym;
  logic       in_vld, in_last, in_rdy;
  logic [3:0] out_cnt;
  logic       out_vld, out_rdy, busy;

  int checks   = 0;
  int failures = 0;

  logic [3:0] got   [16];
  logic [3:0] exp_s [16];
  int got_n, busy_cycles, first_vld, stall_err, rdy_err;

  ans_freq_counter dut (
    .clk     (clk),
    .rst     (rst),
    .in_sym  (in_sym),
    .in_vld  (in_vld),
    .in_last (in_last),
    .in_rdy  (in_rdy),
    .out_cnt (out_cnt),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Called on a falling edge; offers one beat and returns on the next falling edge.
  task automatic beat(input logic [3:0] s, input logic last);
    in_sym  = s;
    in_vld  = 1'b1;
    in_last = last;
    @(negedge clk);
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  // Drains one table; alt toggles out_rdy, hold_in keeps a bogus last beat offered.
  task automatic collect(input bit alt, input bit hold_in);
    logic [3:0] prev;
    bit         prev_stall;
    got_n = 0; busy_cycles = 0; first_vld = -1; stall_err = 0; rdy_err = 0;
    prev_stall = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (busy) busy_cycles++;
      if (busy && in_rdy) rdy_err++;
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (prev_stall && out_cnt !== prev) stall_err++;
      if (!busy && got_n == 16) break;
      out_rdy = alt ? cyc[0] : 1'b1;
      if (hold_in) begin
        in_vld = 1'b1; in_sym = 4'd9; in_last = 1'b1;
      end
      if (out_vld && out_rdy && got_n < 16) begin
        got[got_n] = out_cnt;
        got_n++;
      end
      prev_stall = out_vld && !out_rdy;
      prev       = out_cnt;
      @(negedge clk);
    end
    in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; in_last = 1'b0; in_sym = '0; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy); end
    checks++; if (out_cnt !== 4'd0) begin failures++; $display("FAIL reset_out_cnt got=%0d exp=0", out_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL release_in_rdy got=%b exp=0", in_rdy); end
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL post_release_in_rdy got=%b exp=1", in_rdy); end
  endtask

  task automatic test_single_symbol();
    for (int i = 0; i < 16; i++) beat(4'd3, i == 15);
    collect(1'b0, 1'b0);
    foreach (exp_s[i]) exp_s[i] = 4'd0;
    exp_s[3] = 4'd8;
    checks++; if (got_n !== 16) begin failures++; $display("FAIL single_count got=%0d exp=16", got_n); end
    checks++; if (first_vld !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", first_vld); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== exp_s[i]) begin failures++; $display("FAIL single_stream[%0d] got=%0d exp=%0d", i, got[i], exp_s[i]); end
    end
  endtask

  task automatic test_all_symbols();
    for (int i = 0; i < 16; i++) beat(4'(i), i == 15);
    collect(1'b0, 1'b0);
    checks++; if (busy_cycles !== 17) begin failures++; $display("FAIL all_busy_cycles got=%0d exp=17", busy_cycles); end
    checks++; if (rdy_err !== 0) begin failures++; $display("FAIL all_in_rdy_busy got=%0d exp=0", rdy_err); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 4'd1) begin failures++; $display("FAIL all_stream[%0d] got=%0d exp=1", i, got[i]); end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) beat(4'd5, 1'b0);
    beat(4'd6, 1'b1);
    collect(1'b0, 1'b0);
    foreach (exp_s[i]) exp_s[i] = 4'd0;
    exp_s[5] = 4'd15;
    exp_s[6] = 4'd1;
    checks++; if (got_n !== 16) begin failures++; $display("FAIL sat_count got=%0d exp=16", got_n); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== exp_s[i]) begin failures++; $display("FAIL sat_stream[%0d] got=%0d exp=%0d", i, got[i], exp_s[i]); end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) beat(4'd0, 1'b0);
    for (int i = 0; i < 5; i++) beat(4'd1, 1'b0);
    beat(4'd15, 1'b0);
    beat(4'd15, 1'b1);
    collect(1'b1, 1'b1);
    foreach (exp_s[i]) exp_s[i] = 4'd0;
    exp_s[0] = 4'd3; exp_s[1] = 4'd5; exp_s[15] = 4'd2;
    checks++; if (got_n !== 16) begin failures++; $display("FAIL bp_count got=%0d exp=16", got_n); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
    checks++; if (rdy_err !== 0) begin failures++; $display("FAIL bp_in_rdy_busy got=%0d exp=0", rdy_err); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== exp_s[i]) begin failures++; $display("FAIL bp_stream[%0d] got=%0d exp=%0d", i, got[i], exp_s[i]); end
    end
    beat(4'd2, 1'b1);
    collect(1'b0, 1'b0);
    foreach (exp_s[i]) exp_s[i] = 4'd0;
    exp_s[2] = 4'd1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== exp_s[i]) begin failures++; $display("FAIL bp_next_stream[%0d] got=%0d exp=%0d", i, got[i], exp_s[i]); end
    end
  endtask

  task automatic test_reset_mid_emit();
    int hs = 0;
    beat(4'd4, 1'b0);
    beat(4'd4, 1'b1);
    out_rdy = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (hs == 5) break;
      if (out_vld) hs++;
      @(negedge clk);
    end
    checks++; if (hs !== 5) begin failures++; $display("FAIL mid_handshakes got=%0d exp=5", hs); end
    rst = 1'b1;
    #1;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_out_vld got=%b exp=0", out_vld); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL mid_in_rdy got=%b exp=0", in_rdy); end
    checks++; if (out_cnt !== 4'd0) begin failures++; $display("FAIL mid_out_cnt got=%0d exp=0", out_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL mid_rdy_back got=%b exp=1", in_rdy); end
    beat(4'd0, 1'b1);
    collect(1'b0, 1'b0);
    foreach (exp_s[i]) exp_s[i] = 4'd0;
    exp_s[0] = 4'd1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== exp_s[i]) begin failures++; $display("FAIL mid_after_stream[%0d] got=%0d exp=%0d", i, got[i], exp_s[i]); end
    end
  endtask

  task automatic test_back_to_back();
    beat(4'd7, 1'b0);
    beat(4'd7, 1'b0);
    beat(4'd7, 1'b1);
    collect(1'b0, 1'b0);
    checks++; if (got[7] !== 4'd3) begin failures++; $display("FAIL b2b_first[7] got=%0d exp=3", got[7]); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL b2b_in_rdy got=%b exp=1", in_rdy); end
    beat(4'd7, 1'b1);
    collect(1'b0, 1'b0);
    foreach (exp_s[i]) exp_s[i] = 4'd0;
    exp_s[7] = 4'd1;
    checks++; if (got_n !== 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", got_n); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== exp_s[i]) begin failures++; $display("FAIL b2b_stream[%0d] got=%0d exp=%0d", i, got[i], exp_s[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_symbol();
    test_all_symbols();
    test_saturate();
    test_backpressure();
    test_reset_mid_emit();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
